reservation_station: RTL
========================

# reservation_station

Holds decoded ALU-class instructions (arith, arith-imm, LUI, AUIPC, JAL, JALR, branch) until their source operands are available, then dispatches one ready instruction per cycle to the ALU. It sits between the issue/decode stage and the ALU. It snoops the ALU and LSB result broadcasts to wake waiting operands. All dispatch outputs are registered, so the ALU sees a clean one-cycle-delayed request.

## Interface
Parameters:
- RS_SIZE, 16, number of entries (power of two; index width RS_POS_WID = log2(RS_SIZE))

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- rollback  in  1  misprediction flush
- issue_en  in  1  write a new instruction this cycle
- issue_opcode / issue_funct3 / issue_funct7  in  7 / 3 / 1  decoded fields
- issue_rs1_rdy / issue_rs2_rdy  in  1  operand value valid
- issue_rs1_val / issue_rs2_val  in  32  operand value (when rdy)
- issue_rs1_tag / issue_rs2_tag  in  ROB_POS_WID  producing ROB slot (when not rdy)
- issue_imm / issue_pc  in  32  immediate, instruction address
- issue_rob_pos  in  ROB_POS_WID  destination ROB slot
- rs_full  out  1  combinational; 1 when all entries busy
- alu_result / alu_result_rob_pos / alu_result_val  in  1 / ROB_POS_WID / 32  ALU broadcast
- lsb_result / lsb_result_rob_pos / lsb_result_val  in  1 / ROB_POS_WID / 32  LSB broadcast
- alu_en  out  1  dispatch valid (registered)
- alu_opcode / alu_funct3 / alu_funct7  out  7 / 3 / 1
- alu_val1 / alu_val2 / alu_imm / alu_pc  out  32
- alu_rob_pos  out  ROB_POS_WID

## Operation
- Entry state: busy, opcode, funct3, funct7, rdy1, val1, tag1, rdy2, val2, tag2, imm, pc, rob_pos.
- Issue: if issue_en, write to the lowest-index non-busy entry (taken from the current busy vector). The issuer must not assert issue_en while rs_full; if it does, the request is ignored.
- Issue forwarding: if an issued operand is not ready and its tag matches a broadcast (alu_result or lsb_result) in the same cycle, store it as ready with the broadcast value.
- Wakeup: for every busy entry, a not-ready operand whose tag equals a valid broadcast rob_pos becomes ready with that value at the next edge. Both broadcasts are checked independently. If both match, the ALU broadcast wins (equal tags do not occur legally).
- Select: an entry is ready when busy & rdy1 & rdy2. The lowest-index ready entry is dispatched: its fields are latched into the alu_* outputs, alu_en<=1, and busy<=0. With no ready entry, alu_en<=0 and the other outputs hold.
- Issue and dispatch in the same cycle are allowed. A slot freed this cycle is not reusable until the next cycle.
- rollback (with rdy=1): clear all busy bits; alu_en<=0. A same-cycle issue_en is ignored.
- rdy=0: no state changes, outputs hold (alu_en included).
- Reset: all busy=0. alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos = 0. rs_full=0.

## Timing
- Issue with both operands ready at edge N: entry valid after N; alu_en high in cycle N+1 to N+2 (dispatch latency 2 edges).
- Operand woken by a broadcast in cycle M: alu_en high after edge M+2 at the earliest.
- Throughput: one dispatch per cycle; one issue per cycle.
- rs_full depends on registered busy only (no combinational path from issue_en).
- rst takes priority over rollback; rollback takes priority over rdy=0 hold only when rdy=1.

## Structure
- Mydefine.v holds: OP_WID, FUNCT3_WID, ROB_POS_WID, RS_SIZE, RS_POS_WID, and the opcode constants.
- One sub-module, rs_find_first: a parameterised lowest-set-bit encoder returning index + found flag. It is instantiated twice, once for the free slot and once for the ready slot.

## Test plan
- Reset, then issue ADD (val1=5, val2=7, both ready, rob_pos=3) -> alu_en=1 two edges later, alu_val1=5, alu_val2=7, alu_rob_pos=3; next cycle alu_en=0.
- Issue with rs1 tag=6 not ready; two cycles later ALU broadcasts rob_pos=6 val=0x10 -> dispatch with alu_val1=0x10 two edges after the broadcast.
- Issue with rs2 tag=2 while LSB broadcasts rob_pos=2 val=0xAB in the same cycle -> entry captured ready; dispatches with alu_val2=0xAB.
- Fill all 16 entries with blocked operands -> rs_full=1; an issue_en while full is ignored; broadcast releases entry 0 -> rs_full=0 one edge after dispatch.
- Three entries become ready in the same cycle -> dispatched in index order over three consecutive cycles.
- Rollback with 5 busy entries and alu_en high -> next cycle alu_en=0, rs_full=0, no further dispatches; rdy=0 for 3 cycles freezes alu_en and all outputs unchanged.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode constants and the entry record
// for the ALU reservation station.
package reservation_station_pkg;

  localparam int OP_WID      = 7;
  localparam int FUNCT3_WID  = 3;
  localparam int ROB_POS_WID = 4;
  localparam int RS_SIZE     = 16;
  localparam int RS_POS_WID  = $clog2(RS_SIZE);

  localparam logic [OP_WID-1:0] OP_ARITH   = 7'b0110011;
  localparam logic [OP_WID-1:0] OP_ARITH_I = 7'b0010011;
  localparam logic [OP_WID-1:0] OP_LUI     = 7'b0110111;
  localparam logic [OP_WID-1:0] OP_AUIPC   = 7'b0010111;
  localparam logic [OP_WID-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OP_WID-1:0] OP_JALR    = 7'b1100111;
  localparam logic [OP_WID-1:0] OP_BR      = 7'b1100011;

  typedef struct packed {
    logic [OP_WID-1:0]      opcode;
    logic [FUNCT3_WID-1:0]  funct3;
    logic                   funct7;
    logic                   rdy1;
    logic [31:0]            val1;
    logic [ROB_POS_WID-1:0] tag1;
    logic                   rdy2;
    logic [31:0]            val2;
    logic [ROB_POS_WID-1:0] tag2;
    logic [31:0]            imm;
    logic [31:0]            pc;
    logic [ROB_POS_WID-1:0] rob_pos;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_find_first.sv
// Lowest-set-bit encoder: index of the first 1 and a found flag.
// Used for both free-slot and ready-slot selection.
module rs_find_first #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // scan high to low so the lowest set bit is the last one written
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds instructions until both operands
// are known, snoops result broadcasts, dispatches one per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   issue_en,
  input  logic [OP_WID-1:0]      issue_opcode,
  input  logic [FUNCT3_WID-1:0]  issue_funct3,
  input  logic                   issue_funct7,
  input  logic                   issue_rs1_rdy,
  input  logic                   issue_rs2_rdy,
  input  logic [31:0]            issue_rs1_val,
  input  logic [31:0]            issue_rs2_val,
  input  logic [ROB_POS_WID-1:0] issue_rs1_tag,
  input  logic [ROB_POS_WID-1:0] issue_rs2_tag,
  input  logic [31:0]            issue_imm,
  input  logic [31:0]            issue_pc,
  input  logic [ROB_POS_WID-1:0] issue_rob_pos,
  output logic                   rs_full,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  input  logic [31:0]            alu_result_val,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
  input  logic [31:0]            lsb_result_val,
  output logic                   alu_en,
  output logic [OP_WID-1:0]      alu_opcode,
  output logic [FUNCT3_WID-1:0]  alu_funct3,
  output logic                   alu_funct7,
  output logic [31:0]            alu_val1,
  output logic [31:0]            alu_val2,
  output logic [31:0]            alu_imm,
  output logic [31:0]            alu_pc,
  output logic [ROB_POS_WID-1:0] alu_rob_pos
);

  localparam int PW = $clog2(RS_SIZE);

  rs_entry_t          r_ent [RS_SIZE];
  logic [RS_SIZE-1:0] r_busy;
  logic               r_en;
  rs_entry_t          r_out;

  logic [RS_SIZE-1:0] w_ready;
  logic [PW-1:0]      w_free_idx;
  logic               w_free_found;
  logic [PW-1:0]      w_sel_idx;
  logic               w_sel_found;
  rs_entry_t          w_new;

  // an entry may go to the ALU once both operands are present
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] & r_ent[i].rdy1 & r_ent[i].rdy2;
    end
  end

  rs_find_first #(.N(RS_SIZE), .W(PW)) u_free (
    .i_vec   (~r_busy),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_find_first #(.N(RS_SIZE), .W(PW)) u_sel (
    .i_vec   (w_ready),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  // build the incoming entry, catching a same-cycle broadcast
  always_comb begin
    w_new.opcode  = issue_opcode;
    w_new.funct3  = issue_funct3;
    w_new.funct7  = issue_funct7;
    w_new.rdy1    = issue_rs1_rdy;
    w_new.val1    = issue_rs1_val;
    w_new.tag1    = issue_rs1_tag;
    w_new.rdy2    = issue_rs2_rdy;
    w_new.val2    = issue_rs2_val;
    w_new.tag2    = issue_rs2_tag;
    w_new.imm     = issue_imm;
    w_new.pc      = issue_pc;
    w_new.rob_pos = issue_rob_pos;
    if (!issue_rs1_rdy) begin
      if (alu_result && alu_result_rob_pos == issue_rs1_tag) begin
        w_new.rdy1 = 1'b1;
        w_new.val1 = alu_result_val;
      end else if (lsb_result && lsb_result_rob_pos == issue_rs1_tag) begin
        w_new.rdy1 = 1'b1;
        w_new.val1 = lsb_result_val;
      end
    end
    if (!issue_rs2_rdy) begin
      if (alu_result && alu_result_rob_pos == issue_rs2_tag) begin
        w_new.rdy2 = 1'b1;
        w_new.val2 = alu_result_val;
      end else if (lsb_result && lsb_result_rob_pos == issue_rs2_tag) begin
        w_new.rdy2 = 1'b1;
        w_new.val2 = lsb_result_val;
      end
    end
  end

  // entry payloads: wakeup and issue write (no reset needed)
  always_ff @(posedge clk) begin
    if (!rst && rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_ent[i].rdy1) begin
          if (alu_result && alu_result_rob_pos == r_ent[i].tag1) begin
            r_ent[i].rdy1 <= 1'b1;
            r_ent[i].val1 <= alu_result_val;
          end else if (lsb_result && lsb_result_rob_pos == r_ent[i].tag1) begin
            r_ent[i].rdy1 <= 1'b1;
            r_ent[i].val1 <= lsb_result_val;
          end
        end
        if (r_busy[i] && !r_ent[i].rdy2) begin
          if (alu_result && alu_result_rob_pos == r_ent[i].tag2) begin
            r_ent[i].rdy2 <= 1'b1;
            r_ent[i].val2 <= alu_result_val;
          end else if (lsb_result && lsb_result_rob_pos == r_ent[i].tag2) begin
            r_ent[i].rdy2 <= 1'b1;
            r_ent[i].val2 <= lsb_result_val;
          end
        end
      end
      if (issue_en && w_free_found) begin
        r_ent[w_free_idx] <= w_new;
      end
    end
  end

  // occupancy and registered dispatch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_en   <= 1'b0;
      r_out  <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_busy <= '0;
        r_en   <= 1'b0;
      end else begin
        if (issue_en && w_free_found) begin
          r_busy[w_free_idx] <= 1'b1;
        end
        if (w_sel_found) begin
          r_busy[w_sel_idx] <= 1'b0;
          r_en              <= 1'b1;
          r_out             <= r_ent[w_sel_idx];
        end else begin
          r_en <= 1'b0;
        end
      end
    end
  end

  assign rs_full     = &r_busy;
  assign alu_en      = r_en;
  assign alu_opcode  = r_out.opcode;
  assign alu_funct3  = r_out.funct3;
  assign alu_funct7  = r_out.funct7;
  assign alu_val1    = r_out.val1;
  assign alu_val2    = r_out.val2;
  assign alu_imm     = r_out.imm;
  assign alu_pc      = r_out.pc;
  assign alu_rob_pos = r_out.rob_pos;

endmodule
